// File: rtl/risc16_ctrl_fsm.sv
// rtl/risc16_ctrl_fsm.sv - multi-cycle RISC-16 control unit driving register file, ALU, PC and data memory
module risc16_ctrl_fsm #(
    parameter bit HALT_EN     = 1'b1,
    parameter int ACK_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_eq,
    output logic [2:0]  rA,
    output logic [2:0]  rB,
    output logic [2:0]  rC,
    output logic        MUX_rf,
    output logic [1:0]  MUX_tgt,
    output logic        WE_rf,
    output logic [1:0]  alu_op,
    output logic [1:0]  alu_bsel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halted,
    output logic        err
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((ACK_TIMEOUT > 0) ? (ACK_TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   ir_q, ir_d;
    logic          eq_q, eq_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [2:0] op;
    logic       timeout_hit;
    logic       reads_ra;
    logic       writes_rf;

    assign op          = ir_q[15:13];
    assign timeout_hit = (ACK_TIMEOUT > 0) && (cnt_q == CNT_LAST);
    assign reads_ra    = (op == OP_SW) || (op == OP_BEQ);
    assign writes_rf   = (op != OP_SW) && (op != OP_BEQ) && (ir_q[12:10] != 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q    <= '0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = DECODE;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end else if (ACK_TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                if (HALT_EN && (op == OP_JALR) && (ir_q[6:0] != 7'd0)) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op == OP_BEQ) begin
                    eq_d = alu_eq;
                end
                if ((op == OP_LW) || (op == OP_SW)) begin
                    state_d = MEM;
                    cnt_d   = '0;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (dmem_ack) begin
                    state_d = WB;
                end else if (timeout_hit) begin
                    state_d = ERR;
                end else if (ACK_TIMEOUT > 0) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = FETCH;
        endcase
    end

    // imem_req is qualified by rst_n so every output is quiet while reset is held.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rA       = 3'd0;
        rB       = 3'd0;
        rC       = 3'd0;
        MUX_rf   = 1'b0;
        MUX_tgt  = 2'b00;
        WE_rf    = 1'b0;
        alu_op   = 2'b00;
        alu_bsel = 2'b00;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        halted   = 1'b0;
        err      = 1'b0;
        if (state_q != FETCH) begin
            rA = ir_q[12:10];
            rB = ir_q[9:7];
            rC = ir_q[2:0];
        end
        case (state_q)
            FETCH: imem_req = rst_n;
            DECODE: MUX_rf = reads_ra;
            EXEC: begin
                MUX_rf = reads_ra;
                case (op)
                    OP_ADD:  begin alu_op = 2'b00; alu_bsel = 2'b00; end
                    OP_ADDI: begin alu_op = 2'b00; alu_bsel = 2'b01; end
                    OP_NAND: begin alu_op = 2'b01; alu_bsel = 2'b00; end
                    OP_LUI:  begin alu_op = 2'b10; alu_bsel = 2'b10; end
                    OP_SW:   begin alu_op = 2'b00; alu_bsel = 2'b01; end
                    OP_LW:   begin alu_op = 2'b00; alu_bsel = 2'b01; end
                    OP_BEQ:  begin alu_op = 2'b11; alu_bsel = 2'b00; end
                    default: begin alu_op = 2'b00; alu_bsel = 2'b00; end
                endcase
            end
            MEM: begin
                MUX_rf   = reads_ra;
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
            end
            WB: begin
                MUX_rf = reads_ra;
                pc_we  = 1'b1;
                WE_rf  = writes_rf;
                if ((op == OP_BEQ) && eq_q) begin
                    pc_sel = 2'b01;
                end else if (op == OP_JALR) begin
                    pc_sel = 2'b10;
                end
                if (op == OP_LW) begin
                    MUX_tgt = 2'b00;
                end else if (op == OP_JALR) begin
                    MUX_tgt = 2'b10;
                end else begin
                    MUX_tgt = 2'b01;
                end
            end
            HALT:    halted = 1'b1;
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// tb/tb_risc16_ctrl_fsm.sv - randomized self-checking bench for risc16_ctrl_fsm
module tb_risc16_ctrl_fsm;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        alu_eq;
    logic [2:0]  rA, rB, rC;
    logic        MUX_rf;
    logic [1:0]  MUX_tgt;
    logic        WE_rf;
    logic [1:0]  alu_op;
    logic [1:0]  alu_bsel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halted;
    logic        err;

    int errors = 0;
    int checks = 0;

    risc16_ctrl_fsm #(.HALT_EN(1'b1), .ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .alu_eq     (alu_eq),
        .rA         (rA),
        .rB         (rB),
        .rC         (rC),
        .MUX_rf     (MUX_rf),
        .MUX_tgt    (MUX_tgt),
        .WE_rf      (WE_rf),
        .alu_op     (alu_op),
        .alu_bsel   (alu_bsel),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .halted     (halted),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time budget exhausted");
        $fatal(1);
    end

    // Reference model: architectural meaning of each RISC-16 opcode.
    function automatic logic [3:0] exp_alu(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b00_00;
            3'd1:    return 4'b00_01;
            3'd2:    return 4'b01_00;
            3'd3:    return 4'b10_10;
            3'd4:    return 4'b00_01;
            3'd5:    return 4'b00_01;
            3'd6:    return 4'b11_00;
            default: return 4'b00_00;
        endcase
    endfunction

    function automatic logic exp_we(input logic [15:0] w);
        logic [2:0] op;
        op = w[15:13];
        return (op inside {3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7}) && (w[12:10] != 3'd0);
    endfunction

    function automatic logic [1:0] exp_tgt(input logic [2:0] op);
        if (op == 3'd5) return 2'b00;
        if (op == 3'd7) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic [1:0] exp_pcsel(input logic [2:0] op, input bit eq);
        if (op == 3'd6 && eq) return 2'b01;
        if (op == 3'd7) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        alu_eq     = 1'b0;
        imem_rdata = 16'h0000;
        step();
        step();
        checks++;
        if ({imem_req, dmem_req, dmem_we, rA, rB, rC, MUX_rf, MUX_tgt, WE_rf, alu_op, alu_bsel,
             pc_we, pc_sel, halted, err} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b required=all zero",
                     {imem_req, dmem_req, dmem_we, rA, rB, rC, MUX_rf, MUX_tgt, WE_rf, alu_op,
                      alu_bsel, pc_we, pc_sel, halted, err});
        end
        rst_n = 1'b1;
        #1;
    endtask

    // Drives one instruction from FETCH through WB (or into HALT) and checks every cycle.
    task automatic run_instr(input logic [15:0] w, input int iw, input int dw, input bit eq);
        logic [2:0] op;
        logic       mem;
        logic       hlt;
        logic       mrf;
        op  = w[15:13];
        mem = (op == 3'd4) || (op == 3'd5);
        hlt = (op == 3'd7) && (w[6:0] != 7'd0);
        mrf = (op == 3'd4) || (op == 3'd6);
        alu_eq = eq;
        for (int k = 0; k <= iw; k++) begin
            checks++;
            if ({imem_req, dmem_req, WE_rf, pc_we} !== 4'b1000) begin
                errors++;
                $display("FAIL fetch w=%h cyc=%0d req/dreq/we/pcwe got=%b required=1000",
                         w, k, {imem_req, dmem_req, WE_rf, pc_we});
            end
            imem_ack   = (k == iw);
            imem_rdata = (k == iw) ? w : 16'($urandom);
            step();
        end
        imem_ack = 1'b0;
        checks++;
        if ({rA, rB, rC, MUX_rf, imem_req, WE_rf, pc_we} !== {w[12:10], w[9:7], w[2:0], mrf, 3'b000}) begin
            errors++;
            $display("FAIL decode w=%h got rA=%0d rB=%0d rC=%0d mux_rf=%b req=%b required rA=%0d rB=%0d rC=%0d mux_rf=%b req=0",
                     w, rA, rB, rC, MUX_rf, imem_req, w[12:10], w[9:7], w[2:0], mrf);
        end
        step();
        if (hlt) begin
            checks++;
            if (halted !== 1'b1) begin
                errors++;
                $display("FAIL halt_entry w=%h halted got=%b required=1", w, halted);
            end
            for (int k = 0; k < 20; k++) begin
                checks++;
                if ({pc_we, WE_rf, imem_req, dmem_req, halted} !== 5'b00001) begin
                    errors++;
                    $display("FAIL halt_hold cyc=%0d pcwe/we/req/dreq/halted got=%b required=00001",
                             k, {pc_we, WE_rf, imem_req, dmem_req, halted});
                end
                step();
            end
            return;
        end
        checks++;
        if ((op != 3'd7 && {alu_op, alu_bsel} !== exp_alu(op)) || MUX_rf !== mrf ||
            {WE_rf, pc_we, imem_req} !== 3'b000) begin
            errors++;
            $display("FAIL exec w=%h alu_op/bsel got=%b required=%b mux_rf got=%b required=%b strobes=%b",
                     w, {alu_op, alu_bsel}, exp_alu(op), MUX_rf, mrf, {WE_rf, pc_we, imem_req});
        end
        step();
        alu_eq = 1'($urandom);
        if (mem) begin
            for (int k = 0; k <= dw; k++) begin
                checks++;
                if ({dmem_req, dmem_we, imem_req, WE_rf, pc_we, MUX_rf} !== {1'b1, op == 3'd4, 3'b000, mrf}) begin
                    errors++;
                    $display("FAIL mem w=%h cyc=%0d dreq/dwe/req/we/pcwe/muxrf got=%b required=%b",
                             w, k, {dmem_req, dmem_we, imem_req, WE_rf, pc_we, MUX_rf},
                             {1'b1, op == 3'd4, 3'b000, mrf});
                end
                dmem_ack = (k == dw);
                step();
            end
            dmem_ack = 1'b0;
        end
        checks++;
        if ({pc_we, WE_rf, MUX_tgt, pc_sel, imem_req, dmem_req} !==
            {1'b1, exp_we(w), exp_tgt(op), exp_pcsel(op, eq), 2'b00}) begin
            errors++;
            $display("FAIL wb w=%h eq=%b pcwe/we/tgt/pcsel/req/dreq got=%b required=%b",
                     w, eq, {pc_we, WE_rf, MUX_tgt, pc_sel, imem_req, dmem_req},
                     {1'b1, exp_we(w), exp_tgt(op), exp_pcsel(op, eq), 2'b00});
        end
        step();
    endtask

    task automatic test_reset();
        do_reset();
        run_instr(16'h0503, 0, 0, 1'b0);
    endtask

    task automatic test_load_store();
        run_instr(16'hA885, 0, 3, 1'b0);
        run_instr(16'h8885, 1, 0, 1'b0);
    endtask

    task automatic test_branch_jump();
        run_instr(16'hC481, 0, 0, 1'b1);
        run_instr(16'hC481, 0, 0, 1'b0);
        run_instr(16'h2083, 0, 0, 1'b0);
        run_instr(16'hFC80, 2, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            if (w[15:13] == 3'd7) w[6:0] = 7'd0;
            run_instr(w, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid_mem();
        imem_ack   = 1'b1;
        imem_rdata = 16'hA885;
        step();
        imem_ack = 1'b0;
        step();
        step();
        checks++;
        if (dmem_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_mem_setup dmem_req got=%b required=1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dmem_req, imem_req, WE_rf, pc_we} !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset dreq/req/we/pcwe got=%b required=0000",
                     {dmem_req, imem_req, WE_rf, pc_we});
        end
        step();
        rst_n = 1'b1;
        #1;
        run_instr(16'h0503, 0, 0, 1'b0);
    endtask

    task automatic test_halt();
        run_instr(16'hE001, 0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_reset();
        imem_ack = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            checks++;
            if ({err, imem_req} !== 2'b01) begin
                errors++;
                $display("FAIL timeout_wait cyc=%0d err/req got=%b required=01", k, {err, imem_req});
            end
            step();
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({err, imem_req, dmem_req} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_err cyc=%0d err/req/dreq got=%b required=100",
                         k, {err, imem_req, dmem_req});
            end
            imem_ack = 1'b1;
            step();
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b0;
        alu_eq     = 1'b0;
        imem_rdata = 16'h0000;
        test_reset();
        test_load_store();
        test_branch_jump();
        test_random();
        test_reset_mid_mem();
        test_halt();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
